// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and a registered carry
// process one bit pair per clock and deliver a WIDTH-bit sum plus carry-out.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_next;
    logic           c_reg;
    logic [CW-1:0]  cnt;
    logic           cell_sum;
    logic           cell_carry;

    full_adder u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .sum  (cell_sum),
        .cout (cell_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign s_next = WIDTH'({cell_sum, s_sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            a_sr           <= '0;
            b_sr           <= '0;
            s_sr           <= '0;
            c_reg          <= 1'b0;
            cnt            <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            Data_out_Sum   <= '0;
            Data_out_Carry <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_sr  <= Data_in_A;
                        b_sr  <= Data_in_B;
                        c_reg <= Data_in_C;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    c_reg <= cell_carry;
                    s_sr  <= s_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Data_out_Sum   <= s_next;
                        Data_out_Carry <= cell_carry;
                        Busy           <= 1'b0;
                        Done           <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against plain-arithmetic expected sums and accept-to-done timing.

module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, c8, start1, c1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       busy8, done8, carry8, busy1, done1, carry1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .Start(start8),
        .Data_in_A(a8), .Data_in_B(b8), .Data_in_C(c8),
        .Busy(busy8), .Done(done8),
        .Data_out_Sum(sum8), .Data_out_Carry(carry8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .Start(start1),
        .Data_in_A(a1), .Data_in_B(b1), .Data_in_C(c1),
        .Busy(busy1), .Done(done1),
        .Data_out_Sum(sum1), .Data_out_Carry(carry1)
    );

    typedef struct {
        logic [8:0] res;
        int         due;
    } exp_t;

    exp_t       q8[$];
    exp_t       q1[$];
    exp_t       e8, e1;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         free8 = 0, free1 = 0;
    int         acc8 = -100, acc1 = -100;
    int         n_acc8 = 0;
    logic [8:0] held8 = '0;
    logic [1:0] held1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called right after a negedge: the next posedge is cycle cyc+1, and the
    // DUT accepts Start there only if its previous addition has finished.
    task automatic drive8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
        start8 = s; a8 = a; b8 = b; c8 = c;
        if (s && cyc + 1 >= free8) begin
            q8.push_back('{res: 9'(a) + 9'(b) + 9'(c), due: cyc + 1 + 8});
            acc8  = cyc + 1;
            free8 = cyc + 1 + 9;
            n_acc8++;
        end
    endtask

    task automatic drive1(input logic s, input logic a, input logic b, input logic c);
        start1 = s; a1 = a; b1 = b; c1 = c;
        if (s && cyc + 1 >= free1) begin
            q1.push_back('{res: 9'(a) + 9'(b) + 9'(c), due: cyc + 1 + 1});
            acc1  = cyc + 1;
            free1 = cyc + 1 + 2;
        end
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        drive8(1'b1, a, b, c);
        idle8(9);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_output("busy8_done8_exclusive", 32'(busy8 & done8), 32'd0);
            check_output("busy8", 32'(busy8), 32'(cyc >= acc8 && cyc < acc8 + 8));
            if (done8) begin
                if (q8.size() == 0) begin
                    check_output("done8_unexpected", 32'(done8), 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    check_output("sum8", 32'({carry8, sum8}), 32'(e8.res));
                    check_output("latency8", 32'(cyc), 32'(e8.due));
                    held8 = e8.res;
                end
            end else begin
                check_output("hold8", 32'({carry8, sum8}), 32'(held8));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_output("busy1_done1_exclusive", 32'(busy1 & done1), 32'd0);
            check_output("busy1", 32'(busy1), 32'(cyc == acc1));
            if (done1) begin
                if (q1.size() == 0) begin
                    check_output("done1_unexpected", 32'(done1), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check_output("sum1", 32'({carry1, sum1}), 32'(e1.res[1:0]));
                    check_output("latency1", 32'(cyc), 32'(e1.due));
                    held1 = e1.res[1:0];
                end
            end else begin
                check_output("hold1", 32'({carry1, sum1}), 32'(held1));
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_busy8", 32'(busy8), 32'd0);
        check_output("reset_done8", 32'(done8), 32'd0);
        check_output("reset_sum8", 32'({carry8, sum8}), 32'd0);
        check_output("reset_sum1", 32'({busy1, done1, carry1, sum1}), 32'd0);
        rst = 1'b0;

        // Directed additions, each result held through the following run.
        apply_stimulus(8'h00, 8'h00, 1'b0);
        apply_stimulus(8'hFF, 8'h01, 1'b0);
        apply_stimulus(8'hA5, 8'h5A, 1'b1);
        apply_stimulus(8'h3C, 8'h42, 1'b0);

        // Start held high: operands only matter on accepting edges.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cyc + 1 >= free8) drive8(1'b1, 8'h10, 8'h20, 1'b1);
            else drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle8(10);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        drive8(1'b1, 8'hF0, 8'h0F, 1'b0);
        idle8(4);
        #2 rst = 1'b1;
        #1;
        check_output("midrun_reset_busy8", 32'(busy8), 32'd0);
        check_output("midrun_reset_done8", 32'(done8), 32'd0);
        check_output("midrun_reset_sum8", 32'({carry8, sum8}), 32'd0);
        q8.delete();
        free8 = 0; acc8 = -100; held8 = '0;
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply_stimulus(8'h01, 8'h01, 1'b0);

        // WIDTH=1: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            drive1(1'b1, v[2], v[1], v[0]);
            @(negedge clk);
            drive1(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            drive1(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Random operands and random Start gaps.
        n_acc8 = 0;
        guard = 0;
        while (n_acc8 < 1000 && guard < 40000) begin
            @(negedge clk);
            drive8(1'($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
            guard++;
        end
        check_output("random_accepts", 32'(n_acc8), 32'd1000);

        guard = 0;
        while ((q8.size() != 0 || q1.size() != 0) && guard < 40) begin
            idle8(1);
            guard++;
        end
        check_output("pending8", 32'(q8.size()), 32'd0);
        check_output("pending1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial, LSB-first adder for two WIDTH-bit operands plus carry-in. It uses a single full-adder cell and a registered carry. The block consumes one Data_out_Sum/Data_out_Carry bit-pair from that cell per clock and accumulates the results into a WIDTH-bit sum and a final carry-out. It sits directly downstream of the full_adder cell, which it instantiates. It trades latency for area in the datapath's low-cost arithmetic path.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
Start  input  1  request to begin an addition; sampled on rising clk edge
Data_in_A  input  WIDTH  operand A; captured on accepted Start
Data_in_B  input  WIDTH  operand B; captured on accepted Start
Data_in_C  input  1  carry-in; captured on accepted Start
Busy  output  1  high while the addition is in progress (RUN state)
Done  output  1  one-cycle pulse when the result registers are updated
Data_out_Sum  output  WIDTH  result sum; held until the next completion
Data_out_Carry  output  1  result carry-out; held until the next completion

Behaviour:
- Reset (async assert, any state): state=IDLE; Busy=0, Done=0, Data_out_Sum=0, Data_out_Carry=0; operand, sum and carry regs and bit counter all cleared. Reset mid-RUN aborts with no Done, and the outputs read 0.
- States: IDLE, RUN, DONE. Encoding is free; there are no unreachable-state lockups, and any illegal state goes to IDLE.
- IDLE, Start=1: load A_sr<=Data_in_A, B_sr<=Data_in_B, c_reg<=Data_in_C, cnt<=0, go to RUN. Start=0: stay in IDLE.
- RUN, each cycle:
  - Bit cell inputs are A_sr[0], B_sr[0], c_reg.
  - c_reg <= cell carry.
  - S_sr <= {cell sum, S_sr[WIDTH-1:1]}, i.e. shift in at the MSB.
  - A_sr and B_sr shift right by 1 with zero fill.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- RUN to DONE transition edge: Data_out_Sum <= final shifted sum, Data_out_Carry <= final carry. DONE state drives Done=1 for exactly one cycle.
- DONE: Busy=0, Done=1. Start=1 here is accepted exactly as in IDLE (back-to-back, go to RUN). Otherwise go to IDLE.
- Start while in RUN is ignored: no reload, no queueing.
- Busy=1 only in RUN. Done and Busy are never both high.
- Latency: Start accepted at edge k gives Busy high from k to k+WIDTH, Done high from k+WIDTH to k+WIDTH+1, with the result valid from edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- Arithmetic: {Data_out_Carry, Data_out_Sum} = Data_in_A + Data_in_B + Data_in_C, exact in WIDTH+1 bits with no truncation.
- Data_out_Sum and Data_out_Carry change only on completion or reset. They remain stable while a new RUN is in progress.
- cnt width is max(1, clog2(WIDTH)). WIDTH=1 gives a single RUN cycle.
- Inputs Data_in_* are don't-care except on the accepting edge.

Test Plan:
- WIDTH=8, A=0x00, B=0x00, C=0, Start pulse -> Busy high for 8 cycles; Done pulses 1 cycle; Sum=0x00, Carry=0.
- WIDTH=8, A=0xFF, B=0x01, C=0 -> Sum=0x00, Carry=1. Then A=0xA5, B=0x5A, C=1 -> Sum=0x00, Carry=1. Then A=0x3C, B=0x42, C=0 -> Sum=0x7E, Carry=0. Previous result stays held during each RUN.
- WIDTH=8, Start held high continuously with A=0x10, B=0x20, C=1 -> Done every 9 cycles, Sum=0x31, Carry=0. Operand changes during RUN have no effect.
- WIDTH=8, assert rst at cycle 4 of RUN for A=0xF0, B=0x0F -> all outputs 0 immediately (async), no Done. After release, IDLE; a new Start with A=0x01, B=0x01, C=0 -> Sum=0x02, Carry=0.
- WIDTH=1, all 8 combinations of A, B, C -> Sum/Carry match the full-adder truth table (e.g. 1,1,1 -> Sum=1, Carry=1). Done arrives 1 cycle after Start is accepted.
- WIDTH=8, 1000 random A/B/C with random Start gaps -> every Done result equals A+B+C in 9 bits. Busy and Done are never both high.
